// File: rtl/iotdf_pkg.sv
// iotdf_pkg: shared widths, function codes and serializer states for the IoT data filter output path
package iotdf_pkg;
  localparam int IOT_WORD_W = 128;
  localparam int IOT_BYTE_W = 8;
  localparam int BYTES_PER_WORD = 16;
  typedef enum logic [2:0] {
    FN_NONE = 3'd0,
    FN_MAX  = 3'd1,
    FN_MIN  = 3'd2,
    FN_AVG  = 3'd3,
    FN_EXT  = 3'd4,
    FN_EXC  = 3'd5,
    FN_PMAX = 3'd6,
    FN_PMIN = 3'd7
  } iot_fn_e;
  typedef enum logic {S_IDLE, S_SEND} ser_state_e;
endpackage

// File: rtl/iotdf_res_fifo.sv
// iotdf_res_fifo: synchronous FIFO with combinational head; push and pop may coincide even when full
module iotdf_res_fifo #(
  parameter int W = 131,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = push_i ? wr_q + 1'b1 : wr_q;
    rd_d = pop_i ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + CNT_W'(push_i && !pop_i) - CNT_W'(pop_i && !push_i);
  end
  // A full push+pop writes the slot being read; the head is read before the edge overwrites it.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o = cnt_q == CNT_W'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/iotdf_result_serializer.sv
// iotdf_result_serializer: queues tagged 128-bit filter results and streams them MSB-byte-first over valid/ready
module iotdf_result_serializer
  import iotdf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [IOT_WORD_W-1:0] in_data,
  input  logic [2:0]            in_fn,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IOT_BYTE_W-1:0] out_byte,
  output logic                  out_first,
  output logic                  out_last,
  output logic [2:0]            out_fn,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  full,
  output logic                  overflow,
  input  logic                  clr_ovf
);
  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam int ENT_W = IOT_WORD_W + 3;
  ser_state_e state_q, state_d;
  logic [IOT_WORD_W-1:0] shift_q, shift_d;
  logic [2:0] tag_q, tag_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic ovf_q, ovf_d;
  logic empty, xfer, at_last, pop, push;
  logic [ENT_W-1:0] head;
  assign xfer = state_q == S_SEND && out_ready;
  assign at_last = idx_q == IDX_W'(BYTES_PER_WORD - 1);
  // Reloading on the last byte's transfer keeps back-to-back words bubble-free.
  assign pop = !empty && (state_q == S_IDLE || (xfer && at_last));
  assign push = in_valid && (!full || pop);
  iotdf_res_fifo #(.W(ENT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(pop),
    .wdata_i({in_fn, in_data}),
    .rdata_o(head),
    .count_o(fifo_count),
    .full_o(full),
    .empty_o(empty)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    tag_d = tag_q;
    idx_d = idx_q;
    if (pop) begin
      state_d = S_SEND;
      {tag_d, shift_d} = head;
      idx_d = '0;
    end else if (xfer && at_last) begin
      state_d = S_IDLE;
    end else if (xfer) begin
      shift_d = shift_q << IOT_BYTE_W;
      idx_d = idx_q + 1'b1;
    end
    ovf_d = (in_valid && !push) || (ovf_q && !clr_ovf);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      tag_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      tag_q <= tag_d;
      idx_q <= idx_d;
      ovf_q <= ovf_d;
    end
  end
  assign out_valid = state_q == S_SEND;
  assign out_byte = shift_q[IOT_WORD_W-1 -: IOT_BYTE_W];
  assign out_first = out_valid && idx_q == '0;
  assign out_last = out_valid && at_last;
  assign out_fn = tag_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_iotdf_result_serializer.sv
// tb_iotdf_result_serializer: table-driven and directed checks of the result serializer
module tb_iotdf_result_serializer;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 0, clr_ovf = 0;
  logic [127:0] in_data = '0;
  logic [2:0] in_fn = '0, out_fn;
  logic out_valid, out_first, out_last, full, overflow;
  logic [7:0] out_byte;
  logic [2:0] fifo_count;
  int n_chk = 0, n_fail = 0;

  iotdf_result_serializer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_fn(in_fn),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_first(out_first), .out_last(out_last), .out_fn(out_fn),
    .fifo_count(fifo_count), .full(full), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iv; logic [127:0] d; logic [2:0] fn; logic rdy;
    logic ev; logic [7:0] eb; logic ef; logic el; logic [2:0] efn; logic [2:0] ecnt;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic iv, input logic [127:0] d, input logic [2:0] fn,
                              input logic ev, input logic [7:0] eb, input logic ef, input logic el,
                              input logic [2:0] efn, input logic [2:0] ecnt);
    vec_t v;
    v.iv = iv; v.d = d; v.fn = fn; v.rdy = 1'b1;
    v.ev = ev; v.eb = eb; v.ef = ef; v.el = el; v.efn = efn; v.ecnt = ecnt;
    return v;
  endfunction

  function automatic logic [127:0] wrd(input logic [7:0] base);
    logic [127:0] w = '0;
    for (int i = 0; i < 16; i++) w = {w[119:0], 8'(base + 8'(i))};
    return w;
  endfunction

  task automatic push_word(input int n);
    in_valid = 1; in_data = wrd(8'(n * 16)); in_fn = 3'(n);
    tick();
    in_valid = 0;
  endtask

  task automatic drain(input int n0, input int nw, input bit bp);
    int got, total, k, n, i;
    logic pv, pr, pf, pl;
    logic [7:0] pb;
    logic [2:0] pfn;
    got = 0; total = nw * 16; k = 0; pv = 0; pr = 0; pf = 0; pl = 0; pb = 0; pfn = 0;
    while (got < total && k < 400) begin
      out_ready = bp ? (k % 3 == 0) : 1'b1;
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_byte", out_byte, pb);
        chk("hold_first", out_first, pf);
        chk("hold_last", out_last, pl);
        chk("hold_fn", out_fn, pfn);
      end else if (got > 0) chk("no_gap_valid", out_valid, 1);
      if (out_valid && out_ready) begin
        n = n0 + got / 16; i = got % 16;
        chk("byte", out_byte, {n[3:0], i[3:0]});
        chk("first", out_first, i == 0);
        chk("last", out_last, i == 15);
        chk("fn", out_fn, n[2:0]);
        got++;
      end
      pv = out_valid; pr = out_ready; pb = out_byte; pf = out_first; pl = out_last; pfn = out_fn;
      tick();
      k++;
    end
    if (got < total) chk("drain_timeout", got, total);
  endtask

  initial begin
    logic [127:0] w1;
    logic [127:0] wa, wb;
    w1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    wa = wrd(8'hA0);
    wb = wrd(8'hB0);
    tbl.push_back(mk(1, w1, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int c = 0; c < 16; c++) tbl.push_back(mk(0, 0, 0, 1, 8'(c * 17), c == 0, c == 15, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, wa, 5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, wb, 7, 0, 0, 0, 0, 0, 1));
    for (int c = 0; c < 16; c++) tbl.push_back(mk(0, 0, 0, 1, 8'(8'hA0 + c), c == 0, c == 15, 5, 1));
    for (int c = 0; c < 16; c++) tbl.push_back(mk(0, 0, 0, 1, 8'(8'hB0 + c), c == 0, c == 15, 7, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    @(negedge clk);
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_byte", out_byte, 0);
    chk("rst_fn", out_fn, 0);
    chk("rst_first", out_first, 0);
    chk("rst_last", out_last, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1;
    tick();

    foreach (tbl[j]) begin
      in_valid = tbl[j].iv; in_data = tbl[j].d; in_fn = tbl[j].fn; out_ready = tbl[j].rdy;
      chk($sformatf("tbl%0d_valid", j), out_valid, tbl[j].ev);
      chk($sformatf("tbl%0d_first", j), out_first, tbl[j].ef);
      chk($sformatf("tbl%0d_last", j), out_last, tbl[j].el);
      chk($sformatf("tbl%0d_count", j), fifo_count, tbl[j].ecnt);
      chk($sformatf("tbl%0d_full", j), full, 0);
      chk($sformatf("tbl%0d_ovf", j), overflow, 0);
      if (tbl[j].ev) begin
        chk($sformatf("tbl%0d_byte", j), out_byte, tbl[j].eb);
        chk($sformatf("tbl%0d_fn", j), out_fn, tbl[j].efn);
      end
      tick();
    end
    in_valid = 0;

    push_word(12);
    drain(12, 1, 1);
    chk("bp_idle_after", out_valid, 0);
    chk("bp_count", fifo_count, 0);

    out_ready = 0;
    for (int n = 1; n <= 6; n++) push_word(n);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_full", full, 1);
    chk("ovf_set", overflow, 1);
    chk("ovf_head_valid", out_valid, 1);
    chk("ovf_head_byte", out_byte, 8'h10);
    clr_ovf = 1;
    push_word(7);
    clr_ovf = 0;
    chk("ovf_set_wins", overflow, 1);
    chk("ovf_count_kept", fifo_count, 4);
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("ovf_cleared", overflow, 0);
    drain(1, 5, 0);
    chk("ovf_drain_count", fifo_count, 0);
    chk("ovf_drain_full", full, 0);
    chk("ovf_drain_idle", out_valid, 0);

    out_ready = 0;
    for (int n = 1; n <= 6; n++) push_word(n);
    chk("rm_ovf_pre", overflow, 1);
    out_ready = 1;
    repeat (5) tick();
    chk("rm_mid_byte", out_byte, 8'h15);
    #2 rst = 0;
    #1;
    chk("rm_valid", out_valid, 0);
    chk("rm_count", fifo_count, 0);
    chk("rm_ovf", overflow, 0);
    chk("rm_full", full, 0);
    chk("rm_first", out_first, 0);
    @(negedge clk);
    rst = 1;
    for (int c = 0; c < 6; c++) begin
      chk("rm_quiet", out_valid, 0);
      tick();
    end
    push_word(9);
    chk("rm_lat1", out_valid, 0);
    tick();
    chk("rm_lat2", out_valid, 1);
    drain(9, 1, 0);
    chk("rm_end_idle", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/iotdf_result_serializer.md
Name: iotdf_result_serializer

Overview:
Sits directly downstream of the IoT data filter. It captures every 128-bit result the filter flags with a valid pulse, tagged with the function code active at the time, and queues it in a small FIFO. Each queued word is then streamed out MSB-byte-first as 16 bytes over a valid/ready byte interface toward the chip's 8-bit output pad. A sticky overflow flag reports dropped results.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2. Total capacity is DEPTH plus the one word in the shift register.
CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
clk  input  1  single clock; all logic on the rising edge.
rst  input  1  reset; asynchronous, active-low.
in_valid  input  1  result strobe from the filter's valid output; sampled every cycle.
in_data  input  128  result word from the filter's iot_out.
in_fn  input  3  function code (1..7) tagging in_data.
out_valid  output  1  out_byte is presented.
out_ready  input  1  consumer accepts out_byte this cycle.
out_byte  output  8  current byte; byte 0 = in_data[127:120].
out_first  output  1  high with byte index 0 of a word.
out_last  output  1  high with byte index 15 of a word.
out_fn  output  3  tag of the word being sent; constant across its 16 bytes.
fifo_count  output  CNT_W  number of queued words, excluding the word in the shift register.
full  output  1  fifo_count == DEPTH.
overflow  output  1  sticky: a result was dropped.
clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - out_valid, out_first, out_last, overflow: 0.
  - out_byte, out_fn: 0.
  - fifo_count: 0; full: 0.
  - FIFO pointers and byte index: 0; FSM state: S_IDLE.
- A word partially sent when reset asserts is discarded. After reset releases, no output appears until a new in_valid arrives.
- Push: on a clk edge with in_valid=1, {in_fn, in_data} is written when !full, or when a pop occurs on the same edge. Otherwise the word is dropped and overflow is set.
- overflow clear: clr_ovf=1 clears overflow. If set and clear occur on the same edge, set wins.
- Byte handshake: a byte transfers on an edge where out_valid && out_ready. While out_valid=1 and out_ready=0, out_byte, out_fn, out_first and out_last hold stable, and out_valid never drops.
- FSM S_IDLE:
  - out_valid=0.
  - If fifo_count>0: pop the head into the 128-bit shift register and tag register, set byte index 0, go to S_SEND.
- FSM S_SEND:
  - out_valid=1; out_byte = shift[127:120].
  - On a transfer with index<15: shift left by 8 and increment the index.
  - On a transfer with index==15 and fifo_count>0: pop the next word in the same edge. No bubble; the next cycle shows byte 0 of the new word.
  - On a transfer with index==15 and fifo_count==0: go to S_IDLE.
- Latency: in_valid in cycle t → word written at the end of t → popped at the end of t+1 → out_valid=1 with byte 0 in cycle t+2.
- fifo_count changes as follows on an edge: +1 for an accepted push without pop, −1 for a pop without push, unchanged for both or neither.
- Order is strict FIFO; no reordering and no duplication.
- Pointers wrap modulo DEPTH.
- in_valid pulses on consecutive cycles are legal; the filter's EXT and EXC modes produce them.

Decomposition:
- Package iotdf_pkg:
  - FN_MAX..FN_PMIN codes (1..7).
  - IOT_WORD_W=128, IOT_BYTE_W=8, BYTES_PER_WORD=16.
  - Serializer state enum {S_IDLE, S_SEND}.
- One sub-module, iotdf_res_fifo: a synchronous FIFO of width 131 and depth DEPTH, with push/pop/count/full/empty and simultaneous push+pop allowed when full.
- The top level holds the FSM, shift register, byte index and overflow logic.

Test Plan:
1. Single word 128'h00112233_44556677_8899AABB_CCDDEEFF, in_fn=3, out_ready=1 → out_valid rises 2 cycles later. Bytes are 00,11,…,FF on 16 consecutive cycles, out_first on 00, out_last on FF, out_fn=3 throughout, then out_valid=0.
2. Two words pushed on consecutive cycles, out_ready=1 → 32 contiguous bytes with no bubble between byte 15 of word A and byte 0 of word B; fifo_count returns to 0.
3. Backpressure: out_ready toggles 1,0,0,1,… during one word → each byte is held while out_ready=0, all 16 bytes arrive in order exactly once, and out_valid never deasserts mid-word.
4. Overflow with DEPTH=4 and out_ready=0, 6 pushes on consecutive cycles → fifo_count=4 and full=1. The 6th word is dropped and overflow=1. Releasing out_ready yields words 1..5 in order.
5. Overflow clear priority: overflow=1, then clr_ovf=1 on the same edge as a dropped push → overflow stays 1. clr_ovf=1 alone clears it to 0.
6. Reset mid-word: assert rst=0 after 5 bytes of a word → out_valid, fifo_count and overflow are 0 immediately (asynchronous). After release, no output until the next in_valid, and the new word starts at byte 0.
